ledpanel_write_scheduler: RTL
=============================

Name: ledpanel_write_scheduler

Overview:
Owns the panel write bus (ctrl_en / ctrl_addr / ctrl_wdat) that feeds every ledpanel instance. Arbitrates between two pixel sources:
- the network pixel stream from the Ethernet receiver;
- a local pattern generator (no-signal / test image).

Validates and linearises each pixel coordinate, then issues one registered write per accepted beat. A link watchdog returns bus ownership to the pattern source when network traffic stops.

Parameters:
NUM_PANELS, 8, number of panels on the bus; valid panel indices are 1..NUM_PANELS.
WIDTH, 96, panel width in pixels.
HEIGHT, 48, panel height in pixels; WIDTH*HEIGHT must be <= 65536.
DATA_W, 24, pixel width in bits (RGB888: R in [7:0], G in [15:8], B in [23:16]).
TIMEOUT_CYCLES, 25000000, idle cycles in NET before falling back to PATTERN (>= 2).

Ports:
display_clock  in  1  single clock for the block and the panel bus.
display_reset_n  in  1  asynchronous active-low reset.
net_valid  in  1  network beat valid.
net_ready  out  1  network beat accepted.
net_sof  in  1  first beat of a network frame.
net_panel  in  8  target panel index.
net_x  in  7  column.
net_y  in  6  row.
net_data  in  DATA_W  pixel.
pat_valid  in  1  pattern beat valid.
pat_ready  out  1  pattern beat accepted.
pat_panel  in  8  target panel index.
pat_x  in  7  column.
pat_y  in  6  row.
pat_data  in  DATA_W  pixel.
ctrl_en  out  8  panel select; 0 = no write.
ctrl_addr  out  16  linear address y*WIDTH+x.
ctrl_wdat  out  DATA_W  pixel to write.
link_active  out  1  1 while in NET state.
drop_count  out  16  saturating count of discarded beats.

Behaviour:
- Clock and reset are decided: single clock display_clock; display_reset_n is asynchronous, active-low.
- Reset values:
  - state = PATTERN;
  - ctrl_en = 0, ctrl_addr = 0, ctrl_wdat = 0;
  - link_active = 0, drop_count = 0;
  - watchdog counter = 0.
- Reset mid-operation: any in-flight write is discarded; ctrl_en = 0 asynchronously.
- Handshake: a beat transfers on valid && ready in the same cycle. Source fields must be stable while valid is high.
- net_ready = 1 whenever out of reset. The network sink never stalls; unusable beats are dropped, not back-pressured.
- pat_ready = (state == PATTERN) && !(net_valid && net_sof).
- State PATTERN:
  - a pattern beat is accepted when pat_valid && pat_ready.
  - net beat with net_sof = 1: accepted, written, state -> NET next cycle. Any concurrent pat beat is not accepted.
  - net beat with net_sof = 0: accepted, dropped, drop_count++.
- State NET:
  - only net beats are written; net_sof is ignored.
  - the watchdog clears to 0 on every accepted net beat and otherwise increments.
  - when the watchdog reaches TIMEOUT_CYCLES-1: state -> PATTERN and the watchdog clears.
  - a net beat in that same cycle wins: the watchdog clears and the state stays NET.
- link_active is a registered copy of (state == NET).
- Validation: a beat is writable iff 1 <= panel <= NUM_PANELS, x < WIDTH and y < HEIGHT. Otherwise it is accepted and discarded, and drop_count increments.
- drop_count saturates at 0xFFFF; it is only cleared by reset.
- Write issue, 1-cycle latency: a beat accepted in cycle N produces in cycle N+1:
  - ctrl_en = panel;
  - ctrl_addr = y*WIDTH+x, computed in 16 bits, zero-extended;
  - ctrl_wdat = data.
- In any cycle without a writable accepted beat, ctrl_en = 0. ctrl_addr and ctrl_wdat hold their last value.
- Sustained throughput: one write per cycle, with no bubbles on back-to-back beats.

Decomposition:
- Shared package ledpanel_pkg holds:
  - panel geometry constants (WIDTH, HEIGHT, NUM_PANELS);
  - the pixel-beat field widths (panel, x, y, DATA_W);
  - the source-state enum {PATTERN, NET}.
- Sub-module ledpanel_link_watchdog:
  - counter with clear and increment inputs, parameterised by TIMEOUT_CYCLES;
  - outputs a one-cycle expire pulse;
  - reset asynchronously by display_reset_n.
- Source mux, validation and address computation stay in the top module.

Test Plan:
1. Reset, then pat_valid=1 with panel=1, x=5, y=2, data=0x0000FF → next cycle ctrl_en=1, ctrl_addr=197, ctrl_wdat=0x0000FF; link_active=0.
2. In PATTERN, net_valid=1 with net_sof=1, panel=2, x=95, y=47 on the same cycle as pat_valid=1 → pat_ready=0; next cycle ctrl_en=2, ctrl_addr=4607; link_active=1 one cycle later.
3. In NET, net beats with panel=9, then x=96, then y=48 → ctrl_en stays 0 for each; drop_count=3; net_ready stays 1.
4. TIMEOUT_CYCLES=16; enter NET, then idle 16 cycles → state back to PATTERN, link_active=0, pat beats accepted again. A net beat on the 16th idle cycle → state stays NET.
5. Stream 1000 back-to-back net beats → exactly 1000 consecutive cycles with ctrl_en != 0 and addresses in order; force drop_count near 0xFFFF by 70000 bad beats → it holds 0xFFFF.
6. Assert display_reset_n=0 asynchronously mid-stream → ctrl_en=0 immediately, before the next clock edge; after release, state is PATTERN and drop_count=0.

Source files
------------

// File: rtl/ledpanel_pkg.sv
// Shared panel geometry, pixel-beat field widths and source-state encoding
// for the LED panel write path.
package ledpanel_pkg;
  localparam int NUM_PANELS = 8;
  localparam int WIDTH      = 96;
  localparam int HEIGHT     = 48;
  localparam int DATA_W     = 24;

  localparam int PANEL_W = 8;
  localparam int X_W     = 7;
  localparam int Y_W     = 6;
  localparam int ADDR_W  = 16;

  typedef enum logic {PATTERN = 1'b0, NET = 1'b1} src_state_e;
endpackage

// File: rtl/ledpanel_link_watchdog.sv
// Idle counter for the network link; pulses o_expire on the cycle the count
// would pass TIMEOUT_CYCLES-1 without a clear.
module ledpanel_link_watchdog #(
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic display_clock,
  input  logic display_reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // A clear in the expiry cycle wins, so the link survives a last-moment beat.
  assign o_expire = i_inc && !i_clr && (r_cnt == LAST);

  always_ff @(posedge display_clock or negedge display_reset_n) begin
    if (!display_reset_n)      r_cnt <= '0;
    else if (i_clr || o_expire) r_cnt <= '0;
    else if (i_inc)             r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/ledpanel_write_scheduler.sv
// Panel write-bus owner: arbitrates network and pattern pixel sources and
// issues one registered write per accepted, in-range beat.
module ledpanel_write_scheduler #(
  parameter int NUM_PANELS     = ledpanel_pkg::NUM_PANELS,
  parameter int WIDTH          = ledpanel_pkg::WIDTH,
  parameter int HEIGHT         = ledpanel_pkg::HEIGHT,
  parameter int DATA_W         = ledpanel_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic                             display_clock,
  input  logic                             display_reset_n,
  input  logic                             net_valid,
  output logic                             net_ready,
  input  logic                             net_sof,
  input  logic [ledpanel_pkg::PANEL_W-1:0] net_panel,
  input  logic [ledpanel_pkg::X_W-1:0]     net_x,
  input  logic [ledpanel_pkg::Y_W-1:0]     net_y,
  input  logic [DATA_W-1:0]                net_data,
  input  logic                             pat_valid,
  output logic                             pat_ready,
  input  logic [ledpanel_pkg::PANEL_W-1:0] pat_panel,
  input  logic [ledpanel_pkg::X_W-1:0]     pat_x,
  input  logic [ledpanel_pkg::Y_W-1:0]     pat_y,
  input  logic [DATA_W-1:0]                pat_data,
  output logic [ledpanel_pkg::PANEL_W-1:0] ctrl_en,
  output logic [ledpanel_pkg::ADDR_W-1:0]  ctrl_addr,
  output logic [DATA_W-1:0]                ctrl_wdat,
  output logic                             link_active,
  output logic [15:0]                      drop_count
);
  import ledpanel_pkg::*;

  localparam logic [31:0] PMAX = 32'(NUM_PANELS);
  localparam logic [31:0] XMAX = 32'(WIDTH);
  localparam logic [31:0] YMAX = 32'(HEIGHT);

  src_state_e         r_state, w_state_nxt;
  logic [PANEL_W-1:0] r_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdat;
  logic               r_link;
  logic [15:0]        r_drop;
  logic [16:0]        w_drop_sum;
  logic               w_net_take, w_pat_take, w_wr_net, w_wr_pat;
  logic               w_net_drop, w_pat_drop, w_expire;

  function automatic logic in_range(input logic [PANEL_W-1:0] p,
                                    input logic [X_W-1:0] x,
                                    input logic [Y_W-1:0] y);
    return (p != '0) && (32'(p) <= PMAX) && (32'(x) < XMAX) && (32'(y) < YMAX);
  endfunction

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

  assign net_ready  = display_reset_n;
  assign pat_ready  = (r_state == PATTERN) && !(net_valid && net_sof);

  // In PATTERN only a start-of-frame network beat may reach the bus.
  assign w_net_take = net_valid && ((r_state == NET) || net_sof);
  assign w_pat_take = pat_valid && pat_ready;
  assign w_wr_net   = w_net_take && in_range(net_panel, net_x, net_y);
  assign w_wr_pat   = w_pat_take && in_range(pat_panel, pat_x, pat_y);
  assign w_net_drop = net_valid && !w_wr_net;
  assign w_pat_drop = w_pat_take && !w_wr_pat;
  assign w_drop_sum = {1'b0, r_drop} + 17'(w_net_drop) + 17'(w_pat_drop);

  ledpanel_link_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .display_clock   (display_clock),
    .display_reset_n (display_reset_n),
    .i_clr           ((r_state != NET) || net_valid),
    .i_inc           (r_state == NET),
    .o_expire        (w_expire)
  );

  always_ff @(posedge display_clock or negedge display_reset_n) begin
    if (!display_reset_n) r_state <= PATTERN;
    else                  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PATTERN: if (net_valid && net_sof) w_state_nxt = NET;
      NET:     if (w_expire)             w_state_nxt = PATTERN;
    endcase
  end

  always_ff @(posedge display_clock or negedge display_reset_n) begin
    if (!display_reset_n) begin
      r_en   <= '0;
      r_addr <= '0;
      r_wdat <= '0;
      r_link <= 1'b0;
      r_drop <= '0;
    end else begin
      r_link <= (r_state == NET);
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_en   <= '0;
      if (w_wr_net) begin
        r_en   <= net_panel;
        r_addr <= lin_addr(net_x, net_y);
        r_wdat <= net_data;
      end else if (w_wr_pat) begin
        r_en   <= pat_panel;
        r_addr <= lin_addr(pat_x, pat_y);
        r_wdat <= pat_data;
      end
    end
  end

  assign ctrl_en     = r_en;
  assign ctrl_addr   = r_addr;
  assign ctrl_wdat   = r_wdat;
  assign link_active = r_link;
  assign drop_count  = r_drop;
endmodule
